// File: rtl/cpu_bus_pkg.sv
// Memory map, IO offsets and FSM state types shared by the CPU memory responder.
package cpu_bus_pkg;

  localparam logic [1:0] IO_PORT_OUT = 2'd0;
  localparam logic [1:0] IO_PORT_IN  = 2'd1;
  localparam logic [1:0] IO_TICK     = 2'd2;
  localparam logic [1:0] IO_STATUS   = 2'd3;

  localparam int unsigned STATUS_BOOT_DONE = 0;

  localparam logic [7:0] UNMAPPED_DATA = 8'hFF;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_DONE,
    ST_RUN
  } state_e;

  // Source of cpu_din, registered alongside the address it was decoded from.
  typedef enum logic [1:0] {
    SEL_RAM,
    SEL_ROM,
    SEL_REG
  } rsel_e;

  function automatic logic io_window_hit(input logic [13:0] addr_hi,
                                         input logic [13:0] base_hi);
    return addr_hi == base_hi;
  endfunction

endpackage

// File: rtl/sync_ram_1rw.sv
// Single-port synchronous RAM with registered, write-first read data.
module sync_ram_1rw #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Array contents are never reset; only the output register is.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= we_i ? wdata_i : mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/cpu_mem_responder.sv
// Memory-side responder for cpu_core: RAM/ROM/IO decode, registered read data,
// and a boot loader that streams a program image into ROM while holding the CPU in reset.
module cpu_mem_responder
  import cpu_bus_pkg::*;
#(
  parameter int unsigned RAM_AW  = 11,
  parameter int unsigned ROM_AW  = 10,
  parameter logic [15:0] IO_BASE = 16'h4000,
  parameter bit          BOOT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_we,
  output logic [7:0]  cpu_din,
  output logic        cpu_reset,
  input  logic        ld_start,
  input  logic        ld_valid,
  input  logic [7:0]  ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  input  logic [7:0]  port_in,
  output logic [7:0]  port_out
);

  localparam state_e RESET_STATE = BOOT_EN ? ST_LOAD : ST_RUN;

  state_e            state_q;
  logic              cpu_reset_q;
  logic              ld_ready_q;
  logic              boot_done_q;
  logic [ROM_AW-1:0] ptr_q;

  logic [7:0] tick_q;
  logic [7:0] port_out_q;
  logic [7:0] io_q, io_d;
  rsel_e      sel_q, sel_d;

  logic              ram_hit, rom_hit, io_hit;
  logic              cpu_wr, ld_accept;
  logic              ram_we, rom_we;
  logic [ROM_AW-1:0] rom_addr;
  logic [7:0]        ram_rdata, rom_rdata;

  always_comb begin
    ram_hit   = cpu_addr[15:RAM_AW] == '0;
    rom_hit   = cpu_addr[15:ROM_AW] == '1;
    io_hit    = io_window_hit(cpu_addr[15:2], IO_BASE[15:2]);
    cpu_wr    = cpu_we && (state_q == ST_RUN);
    ld_accept = (state_q == ST_LOAD) && ld_valid && ld_ready_q;
    ram_we    = cpu_wr && ram_hit;
    rom_we    = ld_accept;
    // The ROM port belongs to the loader only on cycles it accepts a byte;
    // otherwise CPU reads of ROM are served even during LOAD.
    rom_addr  = ld_accept ? ptr_q : cpu_addr[ROM_AW-1:0];
  end

  always_comb begin
    sel_d = SEL_REG;
    io_d  = UNMAPPED_DATA;
    if (ram_hit) begin
      sel_d = SEL_RAM;
    end else if (rom_hit) begin
      sel_d = SEL_ROM;
    end else if (io_hit) begin
      case (cpu_addr[1:0])
        IO_PORT_OUT: io_d = cpu_wr ? cpu_dout : port_out_q;
        IO_PORT_IN:  io_d = port_in;
        IO_TICK:     io_d = tick_q;
        IO_STATUS: begin
          io_d = '0;
          io_d[STATUS_BOOT_DONE] = boot_done_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q      <= SEL_REG;
      io_q       <= '0;
      tick_q     <= '0;
      port_out_q <= '0;
    end else begin
      sel_q  <= sel_d;
      io_q   <= io_d;
      tick_q <= tick_q + 8'd1;
      if (cpu_wr && io_hit && (cpu_addr[1:0] == IO_PORT_OUT)) begin
        port_out_q <= cpu_dout;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RESET_STATE;
      ptr_q       <= '0;
      boot_done_q <= 1'b0;
      cpu_reset_q <= BOOT_EN;
      ld_ready_q  <= BOOT_EN;
    end else begin
      unique case (state_q)
        ST_LOAD: begin
          if (ld_accept) begin
            // Pointer saturates at the top of ROM; a full ROM ends the load.
            if (ptr_q != '1) begin
              ptr_q <= ptr_q + 1'b1;
            end
            if (ld_last || (ptr_q == '1)) begin
              state_q    <= ST_DONE;
              ld_ready_q <= 1'b0;
            end
          end
        end
        ST_DONE: begin
          state_q     <= ST_RUN;
          boot_done_q <= 1'b1;
          cpu_reset_q <= 1'b0;
          ld_ready_q  <= 1'b0;
        end
        ST_RUN: begin
          if (ld_start) begin
            state_q     <= ST_LOAD;
            ptr_q       <= '0;
            boot_done_q <= 1'b0;
            cpu_reset_q <= 1'b1;
            ld_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= RESET_STATE;
          ptr_q       <= '0;
          cpu_reset_q <= BOOT_EN;
          ld_ready_q  <= BOOT_EN;
        end
      endcase
    end
  end

  sync_ram_1rw #(
    .AW(RAM_AW),
    .DW(8)
  ) u_ram (
    .clk_i  (clk),
    .rst_i  (reset),
    .we_i   (ram_we),
    .addr_i (cpu_addr[RAM_AW-1:0]),
    .wdata_i(cpu_dout),
    .rdata_o(ram_rdata)
  );

  sync_ram_1rw #(
    .AW(ROM_AW),
    .DW(8)
  ) u_rom (
    .clk_i  (clk),
    .rst_i  (reset),
    .we_i   (rom_we),
    .addr_i (rom_addr),
    .wdata_i(ld_data),
    .rdata_o(rom_rdata)
  );

  always_comb begin
    case (sel_q)
      SEL_RAM: cpu_din = ram_rdata;
      SEL_ROM: cpu_din = rom_rdata;
      default: cpu_din = io_q;
    endcase
  end

  assign cpu_reset = cpu_reset_q;
  assign ld_ready  = ld_ready_q;
  assign port_out  = port_out_q;

endmodule
